attack_controller: RTL and testbench

ATTACK_CONTROLLER -- requirements
Module: attack_controller

---
 rtl/game_logic_pkg.sv | 61 ++++++
 rtl/button_edge_detect.sv | 29 ++
 rtl/attack_controller.sv | 168 ++++++++++++++++
 tb/tb_attack_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_logic_pkg.sv
// Shared game-logic types: strike codes, attack FSM states, sprite phases and default frame timings.
// Imported by the attack controller and by the health manager that consumes its strike codes.
package game_logic_pkg;

    // Strike code as seen by the health manager; nonzero means "apply damage now".
    typedef enum logic [1:0] {
        AtkNone   = 2'b00,
        AtkLight  = 2'b01,
        AtkMedium = 2'b10,
        AtkHeavy  = 2'b11
    } attack_code_e;

    typedef enum logic [1:0] {
        PhaseIdle     = 2'b00,
        PhaseStartup  = 2'b01,
        PhaseStrike   = 2'b10,
        PhaseRecovery = 2'b11
    } phase_e;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StStartup  = 2'b01,
        StStrike   = 2'b10,
        StRecovery = 2'b11
    } atk_state_e;

    localparam int unsigned DefStartupL = 2;
    localparam int unsigned DefStartupM = 4;
    localparam int unsigned DefStartupH = 6;
    localparam int unsigned DefRecovL   = 4;
    localparam int unsigned DefRecovM   = 8;
    localparam int unsigned DefRecovH   = 12;
    localparam int unsigned DefCntW     = 4;

    // press bits are {heavy, medium, light}; heavier attacks win on coincident presses.
    function automatic attack_code_e select_attack(input logic [2:0] press);
        attack_code_e code;
        if (press[2]) begin
            code = AtkHeavy;
        end else if (press[1]) begin
            code = AtkMedium;
        end else if (press[0]) begin
            code = AtkLight;
        end else begin
            code = AtkNone;
        end
        return code;
    endfunction

    function automatic phase_e state_to_phase(input atk_state_e st);
        phase_e ph;
        unique case (st)
            StIdle:     ph = PhaseIdle;
            StStartup:  ph = PhaseStartup;
            StStrike:   ph = PhaseStrike;
            StRecovery: ph = PhaseRecovery;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector for the three attack buttons (inputs already synchronised).
// A button held through reset is not reported until it has been seen low once.
module button_edge_detect (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_i,
    output logic [2:0] press_o
);

    logic [2:0] btn_q, btn_d;
    logic [2:0] armed_q, armed_d;

    always_comb begin
        btn_d   = btn_i;
        armed_d = armed_q | ~btn_i;
        press_o = btn_i & ~btn_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q   <= '0;
            armed_q <= '0;
        end else begin
            btn_q   <= btn_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/attack_controller.sv
// Attack FSM: startup / one-cycle strike / recovery timed in frame ticks, with a one-deep
// buffer so a press during recovery chains straight into the next attack.
module attack_controller
    import game_logic_pkg::*;
#(
    parameter int unsigned STARTUP_L = DefStartupL,
    parameter int unsigned STARTUP_M = DefStartupM,
    parameter int unsigned STARTUP_H = DefStartupH,
    parameter int unsigned RECOV_L   = DefRecovL,
    parameter int unsigned RECOV_M   = DefRecovM,
    parameter int unsigned RECOV_H   = DefRecovH,
    parameter int unsigned CNT_W     = DefCntW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fight_en,
    input  logic       btn_light,
    input  logic       btn_medium,
    input  logic       btn_heavy,
    output logic [1:0] attack_state,
    output logic       busy,
    output logic [1:0] phase
);

    atk_state_e       state_q, state_d;
    attack_code_e     type_q, type_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buf_valid_q, buf_valid_d;
    attack_code_e     buf_type_q, buf_type_d;
    attack_code_e     attack_state_q, attack_state_d;
    logic             busy_q, busy_d;
    phase_e           phase_q, phase_d;

    logic [2:0]       press;
    attack_code_e     press_code;
    logic             press_valid;
    logic             phase_done;

    button_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .btn_i   ({btn_heavy, btn_medium, btn_light}),
        .press_o (press)
    );

    function automatic logic [CNT_W-1:0] startup_frames(input attack_code_e code);
        logic [CNT_W-1:0] n;
        unique case (code)
            AtkLight:  n = CNT_W'(STARTUP_L);
            AtkMedium: n = CNT_W'(STARTUP_M);
            AtkHeavy:  n = CNT_W'(STARTUP_H);
            AtkNone:   n = '0;
        endcase
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] recov_frames(input attack_code_e code);
        logic [CNT_W-1:0] n;
        unique case (code)
            AtkLight:  n = CNT_W'(RECOV_L);
            AtkMedium: n = CNT_W'(RECOV_M);
            AtkHeavy:  n = CNT_W'(RECOV_H);
            AtkNone:   n = '0;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        buf_valid_d = buf_valid_q;
        buf_type_d  = buf_type_q;

        press_code  = select_attack(press);
        press_valid = fight_en && (press_code != AtkNone);
        // Counting from <=1 rather than ==1 also covers a zero-length phase parameter.
        phase_done  = frame_tick && (cnt_q <= CNT_W'(1));

        if (!fight_en) begin
            state_d     = StIdle;
            type_d      = AtkNone;
            cnt_d       = '0;
            buf_valid_d = 1'b0;
            buf_type_d  = AtkNone;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (press_valid) begin
                        state_d = StStartup;
                        type_d  = press_code;
                        cnt_d   = startup_frames(press_code);
                    end
                end
                StStartup: begin
                    if (phase_done) begin
                        state_d = StStrike;
                        cnt_d   = '0;
                    end else if (frame_tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StStrike: begin
                    state_d = StRecovery;
                    cnt_d   = recov_frames(type_q);
                end
                StRecovery: begin
                    if (press_valid) begin
                        buf_valid_d = 1'b1;
                        buf_type_d  = press_code;
                    end
                    if (phase_done) begin
                        buf_valid_d = 1'b0;
                        buf_type_d  = AtkNone;
                        // A press on the completing edge outranks what was buffered earlier.
                        if (press_valid) begin
                            state_d = StStartup;
                            type_d  = press_code;
                            cnt_d   = startup_frames(press_code);
                        end else if (buf_valid_q) begin
                            state_d = StStartup;
                            type_d  = buf_type_q;
                            cnt_d   = startup_frames(buf_type_q);
                        end else begin
                            state_d = StIdle;
                            type_d  = AtkNone;
                            cnt_d   = '0;
                        end
                    end else if (frame_tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end

        attack_state_d = (state_d == StStrike) ? type_d : AtkNone;
        busy_d         = (state_d != StIdle);
        phase_d        = state_to_phase(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            type_q         <= AtkNone;
            cnt_q          <= '0;
            buf_valid_q    <= 1'b0;
            buf_type_q     <= AtkNone;
            attack_state_q <= AtkNone;
            busy_q         <= 1'b0;
            phase_q        <= PhaseIdle;
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            cnt_q          <= cnt_d;
            buf_valid_q    <= buf_valid_d;
            buf_type_q     <= buf_type_d;
            attack_state_q <= attack_state_d;
            busy_q         <= busy_d;
            phase_q        <= phase_d;
        end
    end

    assign attack_state = attack_state_q;
    assign busy         = busy_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_attack_controller.sv
// Scoreboard bench for attack_controller: stimulus pushes expected strike pulses and busy
// falling edges with their cycle numbers; a negedge monitor pops and compares them.
module tb_attack_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       fight_en;
    logic       btn_light, btn_medium, btn_heavy;
    logic       frame_tick;
    logic [1:0] attack_state;
    logic       busy;
    logic [1:0] phase;

    attack_controller dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .fight_en     (fight_en),
        .btn_light    (btn_light),
        .btn_medium   (btn_medium),
        .btn_heavy    (btn_heavy),
        .attack_state (attack_state),
        .busy         (busy),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick source: either a level driven by stimulus, or a strobe on every edge divisible by 5.
    int   tick_mode  = 0;
    logic tick_level = 1'b0;
    logic tick5      = 1'b0;
    always @(posedge clk) begin
        #1;
        tick5 = ((cyc + 1) % 5 == 0);
    end
    assign frame_tick = (tick_mode == 1) ? tick5 : tick_level;

    typedef struct {
        int kind;   // 0 strike pulse, 1 busy falling edge
        int code;
        int at;
    } ev_t;

    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic busy_prev = 1'b0;

    task automatic expect_ev(input int kind, input int code, input int at);
        ev_t e;
        e.kind = kind;
        e.code = code;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic got_event(input int kind, input int code, input int at);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event kind=%0d code=%0d cycle=%0d, required no event",
                     kind, code, at);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.code != code || e.at != at) begin
                fails++;
                $display("FAIL event got kind=%0d code=%0d cycle=%0d, required kind=%0d code=%0d cycle=%0d",
                         kind, code, at, e.kind, e.code, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (attack_state !== 2'b00) got_event(0, int'(attack_state), cyc);
            if (busy_prev === 1'b1 && busy !== 1'b1) got_event(1, 0, cyc);
        end
        busy_prev = busy;
    end

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %b, required %b", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // b = {heavy, medium, light}; held for one cycle, k is the edge that samples the press.
    task automatic press(input logic [2:0] b, output int k);
        {btn_heavy, btn_medium, btn_light} = b;
        step(1);
        k = cyc;
        {btn_heavy, btn_medium, btn_light} = 3'b000;
    endtask

    initial begin
        int k;
        int j;
        int t1;
        reset      = 1'b1;
        fight_en   = 1'b1;
        {btn_heavy, btn_medium, btn_light} = 3'b000;
        step(3);
        check("reset_attack_state", attack_state, 2'b00);
        check("reset_busy", {1'b0, busy}, 2'b00);
        check("reset_phase", phase, 2'b00);
        reset = 1'b0;
        step(2);
        mon_en = 1'b1;

        // Light attack, tick every cycle.
        tick_level = 1'b1;
        press(3'b001, k);
        expect_ev(0, 1, k + 2);
        expect_ev(1, 0, k + 7);
        check("light_phase_startup", phase, 2'b01);
        check("light_busy", {1'b0, busy}, 2'b01);
        step(2);
        check("light_phase_strike", phase, 2'b10);
        step(1);
        check("light_phase_recovery", phase, 2'b11);
        step(10);

        // Heavy and light together: heavy wins.
        press(3'b101, k);
        expect_ev(0, 3, k + 6);
        expect_ev(1, 0, k + 19);
        step(25);

        // Medium press during light startup is ignored.
        press(3'b001, k);
        expect_ev(0, 1, k + 2);
        expect_ev(1, 0, k + 7);
        press(3'b010, j);
        step(12);

        // Medium buffered during light recovery chains with no idle gap.
        press(3'b001, k);
        expect_ev(0, 1, k + 2);
        expect_ev(0, 2, k + 11);
        expect_ev(1, 0, k + 20);
        step(4);
        press(3'b010, j);
        step(25);

        // Press on the completing edge outranks the buffered heavy.
        press(3'b001, k);
        expect_ev(0, 1, k + 2);
        expect_ev(0, 2, k + 11);
        expect_ev(1, 0, k + 20);
        step(4);
        press(3'b100, j);
        step(1);
        press(3'b010, j);
        step(25);

        // fight_en drop in recovery clears buffer; presses while disabled are ignored.
        press(3'b001, k);
        expect_ev(0, 1, k + 2);
        expect_ev(1, 0, k + 5);
        step(3);
        press(3'b100, j);
        fight_en = 1'b0;
        step(2);
        press(3'b100, j);
        step(3);
        fight_en = 1'b1;
        step(10);
        press(3'b001, k);
        expect_ev(0, 1, k + 2);
        expect_ev(1, 0, k + 7);
        step(12);

        // fight_en dropped in startup one tick before the strike.
        tick_level = 1'b0;
        press(3'b001, k);
        step(2);
        tick_level = 1'b1;
        step(1);
        fight_en = 1'b0;
        expect_ev(1, 0, cyc + 1);
        step(1);
        check("abort_attack_state", attack_state, 2'b00);
        check("abort_phase", phase, 2'b00);
        fight_en = 1'b1;
        step(10);

        // Reset while in STRIKE, heavy held through reset.
        btn_heavy = 1'b1;
        step(1);
        k = cyc;
        expect_ev(0, 3, k + 6);
        expect_ev(1, 0, k + 7);
        step(6);
        reset = 1'b1;
        step(1);
        check("rst_strike_attack_state", attack_state, 2'b00);
        check("rst_strike_phase", phase, 2'b00);
        reset = 1'b0;
        step(15);
        btn_heavy = 1'b0;
        step(2);
        press(3'b100, k);
        expect_ev(0, 3, k + 6);
        expect_ev(1, 0, k + 19);
        step(25);

        // Tick every 5 cycles, heavy attack.
        tick_mode = 1;
        step(3);
        press(3'b100, k);
        t1 = (k / 5 + 1) * 5;
        expect_ev(0, 3, t1 + 25);
        expect_ev(1, 0, t1 + 25 + 60);
        step(t1 + 25 + 70 - k);

        tick_mode = 0;
        step(5);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_events got %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
